// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer: WORDS x 32-bit operands, one word per clock, LSW first.
// Optional MULTIWORD_OVF_FLAG_EN adds a signed-overflow output ovf_o.

module fulladder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o,
  output logic        c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, c_i};

endmodule

module multiword_add_seq #(
  parameter int WORDS = 4,
  parameter int CW    = $clog2(WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                sub_i,
  input  logic                carry_i,
  input  logic [32*WORDS-1:0] a_i,
  input  logic [32*WORDS-1:0] b_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic [32*WORDS-1:0] result_o,
`ifdef MULTIWORD_OVF_FLAG_EN
  output logic                carry_o,
  output logic                ovf_o
`else
  output logic                carry_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LastIdx = CW'(WORDS - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           wordIdx_q, wordIdx_d;
  logic                    carry_q, carry_d;
  logic [WORDS-1:0][31:0]  aReg_q, aReg_d;
  logic [WORDS-1:0][31:0]  bReg_q, bReg_d;
  logic [WORDS-1:0][31:0]  result_q, result_d;
  logic                    carryOut_q, carryOut_d;

  logic [31:0] aWord, bWord, sumWord;
  logic        adderCarry;

  assign aWord = aReg_q[wordIdx_q];
  assign bWord = bReg_q[wordIdx_q];

  fulladder32 uAdder (
    .a_i   (aWord),
    .b_i   (bWord),
    .c_i   (carry_q),
    .sum_o (sumWord),
    .c_o   (adderCarry)
  );

`ifdef MULTIWORD_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic msbCarryIn;

  // The carry into bit 31 is recovered from the MSB sum bit, so the adder needs no extra port.
  assign msbCarryIn = aWord[31] ^ bWord[31] ^ sumWord[31];

  always_comb begin
    ovf_d = ovf_q;
    if (!clear_i && state_q == RUN && wordIdx_q == LastIdx) begin
      ovf_d = msbCarryIn ^ adderCarry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    carry_d    = carry_q;
    aReg_d     = aReg_q;
    bReg_d     = bReg_q;
    result_d   = result_q;
    carryOut_d = carryOut_q;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    valid_o    = 1'b0;

    case (state_q)
      IDLE: ready_o = 1'b1;
      RUN:  busy_o  = 1'b1;
      DONE: valid_o = 1'b1;
      default: ;
    endcase

    // Abort wins over everything, including a start request in IDLE; outputs keep partial values.
    if (clear_i) begin
      state_d   = IDLE;
      wordIdx_d = '0;
      carry_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d   = RUN;
            wordIdx_d = '0;
            aReg_d    = a_i;
            bReg_d    = sub_i ? ~b_i : b_i;
            carry_d   = sub_i ? 1'b1 : carry_i;
          end
        end
        RUN: begin
          result_d[wordIdx_q] = sumWord;
          carry_d             = adderCarry;
          if (wordIdx_q == LastIdx) begin
            state_d    = DONE;
            wordIdx_d  = '0;
            carryOut_d = adderCarry;
          end else begin
            wordIdx_d = wordIdx_q + CW'(1);
          end
        end
        DONE: state_d = IDLE;
        default: begin
          state_d   = IDLE;
          wordIdx_d = '0;
          carry_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wordIdx_q  <= '0;
      carry_q    <= 1'b0;
      aReg_q     <= '0;
      bReg_q     <= '0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      carry_q    <= carry_d;
      aReg_q     <= aReg_d;
      bReg_q     <= bReg_d;
      result_q   <= result_d;
      carryOut_q <= carryOut_d;
    end
  end

  assign result_o = result_q;
  assign carry_o  = carryOut_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (WORDS=4), one task per scenario.
// Define MULTIWORD_OVF_FLAG_EN to also exercise ovf_o.

module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         carry_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         clear_i = 1'b0;
  logic         ready_o, busy_o, valid_o, carry_o;
  logic [W-1:0] result_o;
`ifdef MULTIWORD_OVF_FLAG_EN
  logic         ovf_o;
`endif

  int checks = 0;
  int failures = 0;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_i),
    .sub_i    (sub_i),
    .carry_i  (carry_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .clear_i  (clear_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
`ifdef MULTIWORD_OVF_FLAG_EN
    .carry_o  (carry_o),
    .ovf_o    (ovf_o)
`else
    .carry_o  (carry_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20; i++) begin
      if (ready_o) break;
      tick();
    end
  endtask

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
    a_i = a; b_i = b; sub_i = s; carry_i = c; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until valid_o is observed (0 = never seen).
  task automatic waitValid(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid_o) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                      output int edges);
    waitReady();
    startOp(a, b, s, c);
    waitValid(edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", valid_o); end
    checks++; if (result_o !== '0) begin failures++; $display("[TB] FAIL rst_result got=%h exp=0", result_o); end
    checks++; if (carry_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_carry got=%b exp=0", carry_o); end
`ifdef MULTIWORD_OVF_FLAG_EN
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_ovf got=%b exp=0", ovf_o); end
`endif
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_chain();
    int e;
    doOp({W{1'b1}}, 128'd1, 1'b0, 1'b0, e);
    checks++; if (e !== WORDS) begin failures++; $display("[TB] FAIL cc_latency got=%0d exp=%0d", e, WORDS); end
    checks++; if (result_o !== '0) begin failures++; $display("[TB] FAIL cc_result got=%h exp=0", result_o); end
    checks++; if (carry_o !== 1'b1) begin failures++; $display("[TB] FAIL cc_carry got=%b exp=1", carry_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL cc_pulse got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL cc_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_borrow_chain();
    int e;
    doOp(128'd1 << 96, 128'd1, 1'b1, 1'b0, e);
    checks++; if (e !== WORDS) begin failures++; $display("[TB] FAIL bc_latency got=%0d exp=%0d", e, WORDS); end
    checks++; if (result_o !== 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("[TB] FAIL bc_result got=%h exp=0000_0000_ffff...", result_o); end
    checks++; if (carry_o !== 1'b1) begin failures++; $display("[TB] FAIL bc_carry got=%b exp=1", carry_o); end
    // carry_i must be ignored in subtract mode
    doOp(128'd0, 128'd1, 1'b1, 1'b1, e);
    checks++; if (result_o !== {W{1'b1}}) begin failures++; $display("[TB] FAIL bc_neg_result got=%h exp=all ones", result_o); end
    checks++; if (carry_o !== 1'b0) begin failures++; $display("[TB] FAIL bc_neg_carry got=%b exp=0", carry_o); end
  endtask

  task automatic test_carry_in();
    int busyCnt = 0;
    bit seen = 0;
    waitReady();
    startOp(128'h5, 128'hA, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (busy_o) busyCnt++;
      if (valid_o) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ci_timeout got=%b exp=1", seen); end
    checks++; if (busyCnt !== WORDS) begin failures++; $display("[TB] FAIL ci_busy_cycles got=%0d exp=%0d", busyCnt, WORDS); end
    checks++; if (result_o !== 128'h10) begin failures++; $display("[TB] FAIL ci_result got=%h exp=10", result_o); end
    checks++; if (carry_o !== 1'b0) begin failures++; $display("[TB] FAIL ci_carry got=%b exp=0", carry_o); end
  endtask

  task automatic test_abort();
    int e;
    int validCnt = 0;
    logic [W-1:0] a = {32'd4, 32'd3, 32'd2, 32'd1};
    logic [W-1:0] b = {32'd40, 32'd30, 32'd20, 32'd10};
    waitReady();
    startOp(a, b, 1'b0, 1'b0);
    tick(); tick();
    // Now in RUN at word index 2; words 0 and 1 already written.
    checks++; if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL ab_busy_before got=%b exp=1", busy_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL ab_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL ab_busy got=%b exp=0", busy_o); end
    checks++; if (result_o !== {32'd0, 32'd0, 32'd22, 32'd11}) begin
      failures++; $display("[TB] FAIL ab_partial got=%h exp=words 0,0,22,11", result_o); end
    for (int i = 0; i < 6; i++) begin
      if (valid_o) validCnt++;
      tick();
    end
    checks++; if (validCnt !== 0) begin failures++; $display("[TB] FAIL ab_no_valid got=%0d exp=0", validCnt); end
    doOp(a, b, 1'b0, 1'b0, e);
    checks++; if (e !== WORDS) begin failures++; $display("[TB] FAIL ab_restart_latency got=%0d exp=%0d", e, WORDS); end
    checks++; if (result_o !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
      failures++; $display("[TB] FAIL ab_restart_result got=%h exp=words 44,33,22,11", result_o); end
  endtask

  task automatic test_back_to_back();
    int accEdge[2];
    logic [W-1:0] res[2];
    int accCnt = 0;
    int resCnt = 0;
    bit accepting;
    waitReady();
    a_i = 128'd100; b_i = 128'd200; sub_i = 1'b0; carry_i = 1'b0; start_i = 1'b1;
    for (int e = 0; e < 16; e++) begin
      accepting = ready_o && start_i;
      tick();
      if (accepting && accCnt < 2) begin
        accEdge[accCnt] = e;
        accCnt++;
        a_i = 128'd7; b_i = 128'd8;
      end
      if (valid_o && resCnt < 2) begin
        res[resCnt] = result_o;
        resCnt++;
      end
    end
    start_i = 1'b0;
    checks++; if (accCnt !== 2) begin failures++; $display("[TB] FAIL b2b_accepts got=%0d exp=2", accCnt); end
    checks++; if (resCnt !== 2) begin failures++; $display("[TB] FAIL b2b_valids got=%0d exp=2", resCnt); end
    if (accCnt == 2) begin
      checks++; if (accEdge[1] - accEdge[0] !== 6) begin
        failures++; $display("[TB] FAIL b2b_spacing got=%0d exp=6", accEdge[1] - accEdge[0]); end
    end
    if (resCnt == 2) begin
      checks++; if (res[0] !== 128'd300) begin failures++; $display("[TB] FAIL b2b_first got=%h exp=12c", res[0]); end
      checks++; if (res[1] !== 128'd15) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=f", res[1]); end
    end
  endtask

  task automatic test_async_reset();
    int validCnt = 0;
    waitReady();
    startOp({W{1'b1}}, 128'd1, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL ar_ready got=%b exp=1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL ar_busy got=%b exp=0", busy_o); end
    checks++; if (result_o !== '0) begin failures++; $display("[TB] FAIL ar_result got=%h exp=0", result_o); end
    checks++; if (carry_o !== 1'b0) begin failures++; $display("[TB] FAIL ar_carry got=%b exp=0", carry_o); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_o) validCnt++;
    end
    checks++; if (validCnt !== 0) begin failures++; $display("[TB] FAIL ar_no_valid got=%0d exp=0", validCnt); end
  endtask

`ifdef MULTIWORD_OVF_FLAG_EN
  task automatic test_ovf();
    int e;
    doOp({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0, e);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_add_pos got=%b exp=1", ovf_o); end
    checks++; if (result_o !== {1'b1, {(W-1){1'b0}}}) begin failures++; $display("[TB] FAIL ovf_add_res got=%h", result_o); end
    doOp({1'b1, {(W-1){1'b0}}}, 128'd1, 1'b1, 1'b0, e);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sub_neg got=%b exp=1", ovf_o); end
    checks++; if (carry_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sub_carry got=%b exp=1", carry_o); end
    doOp(128'd3, 128'd4, 1'b0, 1'b0, e);
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_small got=%b exp=0", ovf_o); end
    checks++; if (result_o !== 128'd7) begin failures++; $display("[TB] FAIL ovf_small_res got=%h exp=7", result_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_borrow_chain();
    test_carry_in();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifdef MULTIWORD_OVF_FLAG_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
